// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing the external 4-bit memory bus between two ports
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [9:0] addr0,
  input  logic [9:0] addr1,
  input  logic [3:0] wdata0,
  input  logic [3:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] rdata,
  output logic [9:0] mem_addr,
  output logic [3:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_oe,
  input  logic [3:0] mem_rdata
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_ACCESS = 3'b010,
    S_DONE   = 3'b100
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [2:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [9:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic [3:0] rdata_q, rdata_d;
  logic       pick;
  logic       owns_bus;

  // Under contention the port not granted last wins; a lone request always wins.
  assign pick = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 4'd0;
      rdata_q <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          last_d  = pick;
          cnt_d   = WAIT_INIT;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // last_q already points at the current owner once a grant has been taken.
  assign owns_bus  = (state_q == S_ACCESS) || (state_q == S_DONE);
  assign gnt0      = owns_bus && !last_q;
  assign gnt1      = owns_bus && last_q;
  assign ack0      = (state_q == S_DONE) && !last_q;
  assign ack1      = (state_q == S_DONE) && last_q;
  assign mem_we    = (state_q == S_ACCESS) && we_q;
  assign mem_oe    = mem_we;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized bench for mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int W = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [9:0] addr0 = 10'd0, addr1 = 10'd0;
  logic [3:0] wdata0 = 4'd0, wdata1 = 4'd0, mem_rdata = 4'd0;
  logic       gnt0, gnt1, ack0, ack1, mem_we, mem_oe;
  logic [3:0] rdata, mem_wdata;
  logic [9:0] mem_addr;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Model: one in-flight transaction, tracked by its age in cycles since the grant edge.
  bit         m_busy;
  int         m_age;
  bit         m_own;
  bit         m_last;
  bit         m_we;
  logic [9:0] m_addr;
  logic [3:0] m_wdata;
  logic [3:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_age   = 0;
    m_own   = 1'b0;
    m_last  = 1'b1;
    m_we    = 1'b0;
    m_addr  = 10'd0;
    m_wdata = 4'd0;
    m_rdata = 4'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      m_age++;
      if (m_age == W + 2 && !m_we) m_rdata = mem_rdata;
      if (m_age == W + 3) m_busy = 1'b0;
    end else if (req0 || req1) begin
      m_own   = (req0 && req1) ? !m_last : req1;
      m_last  = m_own;
      m_busy  = 1'b1;
      m_age   = 1;
      m_we    = m_own ? we1 : we0;
      m_addr  = m_own ? addr1 : addr0;
      m_wdata = m_own ? wdata1 : wdata0;
    end
  endtask

  task automatic compare_all();
    bit e_gnt, e_acc, e_ack;
    e_gnt = m_busy && m_age <= W + 2;
    e_acc = m_busy && m_age <= W + 1;
    e_ack = m_busy && m_age == W + 2;
    check("gnt0", 32'(gnt0), 32'(e_gnt && !m_own));
    check("gnt1", 32'(gnt1), 32'(e_gnt && m_own));
    check("ack0", 32'(ack0), 32'(e_ack && !m_own));
    check("ack1", 32'(ack1), 32'(e_ack && m_own));
    check("mem_we", 32'(mem_we), 32'(e_acc && m_we));
    check("mem_oe", 32'(mem_oe), 32'(e_acc && m_we));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_port(input bit p, inout logic r, inout logic w,
                           inout logic [9:0] a, inout logic [3:0] d);
    bit granted;
    granted = m_busy && (m_own == p) && (m_age <= W + 2);
    if (granted && m_age == W + 2) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 10'($urandom);
      d = 4'($urandom);
    end else if (r && granted) begin
      w = 1'($urandom_range(0, 1));
      a = 10'($urandom);
      d = 4'($urandom);
      if ($urandom_range(0, 7) == 0) r = 1'b0;
    end else if (!r && $urandom_range(0, 1) == 1) begin
      r = 1'b1;
      w = 1'($urandom_range(0, 1));
      a = 10'($urandom);
      d = 4'($urandom);
    end
  endtask

  initial begin
    int acks;
    logic [3:0] order;
    model_reset();

    repeat (2) step();
    check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    // Single read on port 0; request and address change once granted.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h123; mem_rdata = 4'hA;
    step();
    check("rd_gnt0_c1", 32'(gnt0), 32'd1);
    addr0 = 10'h000; req0 = 1'b0;
    step();
    check("rd_addr_held", 32'(mem_addr), 32'h123);
    check("rd_we_c2", 32'(mem_we), 32'd0);
    step();
    check("rd_ack0", 32'(ack0), 32'd1);
    check("rd_rdata", 32'(rdata), 32'hA);
    step();
    check("rd_idle_gnt0", 32'(gnt0), 32'd0);

    // Single write on port 1.
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 4'h5; mem_rdata = 4'h3;
    step();
    check("wr_we_c1", 32'({mem_oe, mem_we}), 32'd3);
    check("wr_wdata", 32'(mem_wdata), 32'h5);
    step();
    check("wr_we_c2", 32'({mem_oe, mem_we}), 32'd3);
    step();
    check("wr_ack1", 32'(ack1), 32'd1);
    check("wr_we_done", 32'(mem_we), 32'd0);
    check("wr_rdata_kept", 32'(rdata), 32'hA);
    req1 = 1'b0; we1 = 1'b0;
    step();

    // Continuous contention: acks must alternate starting with port 0.
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    acks = 0; order = 4'd0;
    for (int i = 0; i < 16; i++) begin
      mem_rdata = 4'($urandom);
      step();
      check("cont_ack_overlap", 32'(ack0 && ack1), 32'd0);
      if (ack0 || ack1) begin
        acks++;
        order = {order[2:0], ack1};
      end
    end
    check("cont_acks", 32'(acks), 32'd4);
    check("cont_order", 32'(order), 32'b0101);
    req0 = 1'b0; req1 = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      step();
      check("inv_gnt", 32'(gnt0 && gnt1), 32'd0);
      rand_port(1'b0, req0, we0, addr0, wdata0);
      rand_port(1'b1, req1, we1, addr1, wdata1);
      mem_rdata = 4'($urandom);
    end

    // Drain, then reset in the second access cycle.
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 8 && m_busy; i++) step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h2AA;
    step();
    step();
    check("mid_gnt0_before", 32'(gnt0), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("mid_rst_outs", 32'({gnt0, gnt1, ack0, ack1, mem_we, mem_oe}), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    req0 = 1'b0;
    step();
    rst = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h155; mem_rdata = 4'h6;
    step();
    check("post_gnt1", 32'(gnt1), 32'd1);
    step();
    step();
    check("post_ack1", 32'(ack1), 32'd1);
    check("post_rdata", 32'(rdata), 32'h6);
    req1 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external 4-bit memory bus between two requesters: port 0 (CPU core fetch/load/store) and port 1 (debug/program loader).
- Each granted access is latched, driven onto the bus for a fixed number of cycles, sampled, and acknowledged with a one-cycle pulse.
- Contention is resolved round-robin.
- Sits between the CPU core / loader and the top-level pad mux that drives the external memory pins.

## Interface

- WAIT_CYCLES, default 1: extra bus cycles per access. An access holds the bus for WAIT_CYCLES+1 cycles. Legal range 0–7.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req0, req1  input  1 each  access request, level-sensitive; held high until the matching ack.
- we0, we1  input  1 each  1 = write, 0 = read; sampled at grant.
- addr0, addr1  input  10 each  word address; sampled at grant.
- wdata0, wdata1  input  4 each  write data; sampled at grant.
- gnt0, gnt1  output  1 each  high while that port owns the bus (ACCESS and DONE).
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rdata  output  4  read data; valid in the ack cycle, held until the next capture.
- mem_addr  output  10  bus address.
- mem_wdata  output  4  bus write data.
- mem_we  output  1  bus write strobe.
- mem_oe  output  1  data-pin drive enable; equal to mem_we.
- mem_rdata  input  4  bus read data.

## Operation

States: IDLE, ACCESS, DONE. State is encoded one-hot.

IDLE:
- If neither request is high, stay in IDLE.
- If exactly one request is high, grant that port.
- If both are high, grant the port not granted last. The last-granted pointer resets to 1, so port 0 wins the first contention.
- On a grant, in the same edge:
  - latch the granted port's we/addr/wdata into the bus registers;
  - update the last-granted pointer;
  - load the wait counter with WAIT_CYCLES;
  - go to ACCESS.

ACCESS:
- mem_addr and mem_wdata show the latched values; mem_we = mem_oe = latched we.
- If the counter is nonzero, decrement it and stay.
- If the counter is zero, go to DONE. On that edge:
  - reads capture mem_rdata into rdata;
  - writes leave rdata unchanged.

DONE:
- The granted port's ack is 1 for exactly this cycle.
- mem_we and mem_oe are 0; mem_addr holds its value.
- Next state is always IDLE. No arbitration occurs in DONE, so the acked requester has one cycle to drop or change its request.

Invariants:
- gnt0 and gnt1 are never both high.
- ack0 and ack1 are never both high.
- At most one access is in flight.

## Timing

- Reset: state IDLE, last-granted pointer = 1, wait counter 0. All outputs are 0: gnt0, gnt1, ack0, ack1, rdata, mem_addr, mem_wdata, mem_we, mem_oe.
- A request first seen high in IDLE cycle N produces:
  - ACCESS in cycles N+1 .. N+1+WAIT_CYCLES;
  - DONE/ack in cycle N+2+WAIT_CYCLES;
  - IDLE in cycle N+3+WAIT_CYCLES.
- With WAIT_CYCLES=1 the ack arrives in cycle N+3.
- Throughput: one access per WAIT_CYCLES+3 cycles. A second pending request is granted from the IDLE cycle that follows DONE.
- mem_rdata must be stable in the last ACCESS cycle.
- Request inputs may change freely once granted. Latched values are used, and later changes are ignored.
- If req drops mid-access, the access still completes and ack still pulses.
- If rst asserts mid-access, all state and outputs return to reset values immediately. No ack is produced and the access is abandoned.
- With WAIT_CYCLES=0 there is a single ACCESS cycle, and the counter logic must not underflow.

## Test plan

- Single read, WAIT_CYCLES=1, mem_rdata=4'hA, port 0 req in cycle 0 with addr0=10'h123 -> gnt0 high cycles 1–3; mem_addr=10'h123 and mem_we=0 in cycles 1–2; ack0 pulses in cycle 3 only; rdata=4'hA.
- Single write, port 1, addr1=10'h3FF, wdata1=4'h5 -> mem_we=mem_oe=1 with mem_wdata=4'h5 for exactly 2 cycles; ack1 pulse follows; rdata unchanged from its previous value.
- Contention: req0 and req1 both high continuously from reset -> grants alternate 0,1,0,1; each access takes 4 cycles; ack0 and ack1 never overlap.
- Request changes ignored: change addr0 to 10'h000 and drop req0 in the first ACCESS cycle -> mem_addr still shows the granted address; ack0 still pulses.
- Reset mid-access: assert rst in the second ACCESS cycle -> all outputs 0 asynchronously; no ack. After release, req1 alone is granted normally.
- WAIT_CYCLES=0 build: read -> ack in cycle N+2; back-to-back reads from one port complete every 3 cycles.
